// File: rtl/pipelined_adder.sv
// Elastic, pipelined two's-complement adder/subtractor. The carry chain is cut
// into STAGES registered segments of SEG bits; one result per clock when unstalled.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. valid never depends on ready; ready depends only on out_ready and the
  // registered stage occupancy, so there is no path from in_valid/data to outputs.

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] stage_rdy;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  bp_q  [STAGES];
  logic [WIDTH-1:0]  bp_d  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;

  // A stage may load unless it and every stage after it are full and the
  // consumer is stalling; this is what lets bubbles compress.
  always_comb begin
    logic all_full;
    all_full  = 1'b1;
    stage_rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full     = all_full & valid_q[k];
      stage_rdy[k] = out_ready | ~all_full;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] op_a, op_b, lower;
    logic             c;
    logic [SEG:0]     seg;
    op_a    = '0;
    op_b    = '0;
    lower   = '0;
    c       = 1'b0;
    seg     = '0;
    ovf_d   = 1'b0;
    valid_d = '0;
    carry_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        op_a       = a;
        op_b       = sub ? ~b : b;
        c          = sub ^ cin;
        lower      = '0;
        valid_d[k] = in_valid;
      end else begin
        op_a       = a_q[k-1];
        op_b       = bp_q[k-1];
        c          = carry_q[k-1];
        lower      = sum_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      seg = {1'b0, op_a[k*SEG +: SEG]} + {1'b0, op_b[k*SEG +: SEG]} + {{SEG{1'b0}}, c};
      sum_d[k]                 = lower;
      sum_d[k][k*SEG +: SEG]   = seg[SEG-1:0];
      carry_d[k]               = seg[SEG];
      a_d[k]                   = op_a;
      bp_d[k]                  = op_b;
      // Carry into the MSB is recovered from the MSB's own sum bit.
      if (k == STAGES - 1) begin
        ovf_d = (op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ sum_d[k][WIDTH-1]) ^ seg[SEG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_rdy[k]) begin
          valid_q[k] <= valid_d[k];
          if (valid_d[k]) begin
            a_q[k]     <= a_d[k];
            bp_q[k]    <= bp_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
      if (stage_rdy[STAGES-1] && valid_d[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = stage_rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized checks of pipelined_adder (WIDTH=16, STAGES=4)
// against an arithmetic reference model and an in-order expected queue.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub;
  logic         out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic [W+1:0] exp_q[$];  // {sum, cout, ovf}
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_acc    = 0;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the operands' unsigned and signed values.
  function automatic logic [W+1:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                         logic ci, logic sb);
    int ux, uy, sx, sy, ur, sr;
    logic [W-1:0] s;
    logic c, o;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      c  = (ur >= (1 << W));
    end else begin
      ur = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      c  = (ur >= 0);
    end
    s = ur[W-1:0];
    o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {s, c, o};
  endfunction

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: handshakes are sampled on the falling edge, output transfers are
  // scored against the queue, accepted inputs are modelled after the edge.
  task automatic tick();
    logic acc, xfer;
    logic [W+1:0] m;
    @(negedge clk);
    acc  = in_valid && in_ready && !rst;
    xfer = out_valid && out_ready && !rst;
    m    = model(a, b, cin, sub);
    if (xfer) begin
      n_out++;
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("scoreboard", {sum, cout, ovf}, exp_q.pop_front());
    end
    @(posedge clk);
    if (rst) exp_q.delete();
    else if (acc) begin
      exp_q.push_back(m);
      n_acc++;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_random();
    a   = W'($urandom_range(0, (1 << W) - 1));
    b   = W'($urandom_range(0, (1 << W) - 1));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(string tag);
    int cnt;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Single transaction into an empty pipeline; checks latency and exact result.
  task automatic directed(string tag, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb,
                          logic [W-1:0] es, logic ec, logic eo);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x; b = y; cin = ci; sub = sb;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, S);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    tick();
    check({tag, "_consumed"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int out0, acc0;
    logic [W+1:0] snap;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    directed("carry_all",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_bin",    16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Streaming: 32 back-to-back random transfers with no backpressure.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 32; i++) begin
      drive_random();
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
    end
    check("stream_out_count", n_out - out0, 32 - S);
    drain("stream");
    check("stream_total", n_out - out0, 32);

    // Backpressure from an empty pipeline: exactly S items are absorbed.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc0 = n_acc;
    out0 = n_out;
    snap = '0;
    for (int i = 0; i < 8; i++) begin
      drive_random();
      #1;
      check("bp_in_ready", in_ready, (i < S) ? 1 : 0);
      tick();
      if (i == S - 1) begin
        check("bp_out_valid", out_valid, 1);
        snap = {sum, cout, ovf};
      end else if (i >= S) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", {sum, cout, ovf}, snap);
      end
    end
    check("bp_accepted", n_acc - acc0, S);
    check("bp_no_output", n_out - out0, 0);
    // Release while still streaming: full pipeline accepts and emits every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_random();
      #1;
      check("release_in_ready", in_ready, 1);
      tick();
    end
    check("release_out_count", n_out - out0, 8);
    drain("release");
    check("release_total", n_out - out0, n_acc - acc0);

    // Reset with 3 items in flight and a simultaneous input offered.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick();
    end
    check("mid_inflight_no_out", out_valid, 0);
    rst = 1'b1;
    drive_random();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sum", sum, 0);
    out0 = n_out;
    for (int i = 0; i < 8; i++) tick();
    check("mid_rst_no_ghosts", n_out - out0, 0);
    directed("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
